score_tally_ctrl: RTL

- Score controller for the on-screen score overlay: accumulates point events from game logic and animates the displayed score upward one point per N frames.
- Drives a shared digit bitmap: converts overlay-relative scan offsets into per-digit value and offsets, one pipeline stage deep.
- Sits between game logic (collision/kill events) and the digit bitmap, next to the "SCORE" label bitmap in the VGA object path.

---
 rtl/score_tally_if.sv | 40 ++++
 rtl/score_tally_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/score_tally_if.sv
// Score overlay bus: game-logic events in, digit bitmap drive and score status out.
//
// Handshake semantics: there is no valid/ready pair on this bus. startOfFrame,
// addScore and clearScore are single-cycle pulses sampled on the rising clk edge.
// The controller accepts every pulse unconditionally, so the producer never
// stalls. The pixel inputs are sampled every cycle, and the digit outputs answer
// them exactly one cycle later.
interface score_tally_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    startOfFrame;
  logic                    addScore;
  logic [7:0]              addValue;
  logic                    clearScore;
  logic [10:0]             offsetX;
  logic [10:0]             offsetY;
  logic                    InsideRectangle;
  logic [3:0]              digitValue;
  logic [10:0]             digitOffsetX;
  logic [10:0]             digitOffsetY;
  logic                    digitInside;
  logic [4*NUM_DIGITS-1:0] scoreBCD;
  logic                    busyTally;

  // Game logic / VGA object path side.
  modport master (
    output startOfFrame, addScore, addValue, clearScore,
    output offsetX, offsetY, InsideRectangle,
    input  digitValue, digitOffsetX, digitOffsetY, digitInside,
    input  scoreBCD, busyTally
  );

  // Score controller side.
  modport slave (
    input  startOfFrame, addScore, addValue, clearScore,
    input  offsetX, offsetY, InsideRectangle,
    output digitValue, digitOffsetX, digitOffsetY, digitInside,
    output scoreBCD, busyTally
  );
endinterface

// File: rtl/score_tally_ctrl.sv
// Score overlay controller: collects point events into a pending accumulator,
// animates the BCD score up by one point every TALLY_STEP_FRAMES frames, and
// maps overlay scan offsets onto a shared digit bitmap with one register stage.
// The FSM state is exported on state_dbg: 0 = idle, 1 = wait, 2 = step.
module score_tally_ctrl #(
  parameter int NUM_DIGITS        = 4,
  parameter int DIGIT_WIDTH_BITS  = 4,
  parameter int DIGIT_HEIGHT      = 32,
  parameter int TALLY_STEP_FRAMES = 2,
  parameter int PENDING_WIDTH     = 12
) (
  input  logic         clk,
  input  logic         resetN,
  score_tally_if.slave bus,
  output logic [1:0]   state_dbg
);

  localparam int SW     = 4 * NUM_DIGITS;
  localparam int CNT_W  = (TALLY_STEP_FRAMES > 1) ? $clog2(TALLY_STEP_FRAMES) : 1;
  localparam int PSUM_W = PENDING_WIDTH + 2;
  localparam int SLOT_W = 11 - DIGIT_WIDTH_BITS;

  localparam logic [CNT_W-1:0]         CNT_LAST = CNT_W'(TALLY_STEP_FRAMES - 1);
  localparam logic [PENDING_WIDTH-1:0] PEND_MAX = '1;
  localparam logic [PSUM_W-1:0]        PSUM_MAX = PSUM_W'(PEND_MAX);
  localparam logic [PSUM_W-1:0]        PSUM_ONE = PSUM_W'(1);
  localparam logic [10:0]              HEIGHT_L = 11'(DIGIT_HEIGHT);
  localparam logic [31:0]              DIGITS_L = 32'(NUM_DIGITS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_STEP = 2'd2
  } state_t;

  state_t                     state, state_next;
  logic [CNT_W-1:0]           frame_cnt, frame_cnt_next;
  logic [PENDING_WIDTH-1:0]   pending, pending_next;
  logic [PSUM_W-1:0]          pend_sum;
  logic [SW-1:0]              score, score_next, score_inc;
  logic [SW-1:0]              displayed;
  logic                       all_nines;
  logic                       inc_carry;

  logic [SLOT_W-1:0]          slot;
  logic [31:0]                slot_ext;
  logic                       slot_ok;
  logic [3:0]                 pix_digit;
  logic                       pix_blank;
  logic                       pix_inside;
  logic [NUM_DIGITS-1:0]      blank_mask;
  logic                       lead_zero;

  // BCD +1 with a ripple carry per digit; also flags the all-nines ceiling.
  always_comb begin
    inc_carry = 1'b1;
    all_nines = 1'b1;
    score_inc = score;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (score[4*i +: 4] != 4'd9) begin
        all_nines = 1'b0;
      end
      if (inc_carry) begin
        if (score[4*i +: 4] == 4'd9) begin
          score_inc[4*i +: 4] = 4'd0;
        end else begin
          score_inc[4*i +: 4] = score[4*i +: 4] + 4'd1;
          inc_carry           = 1'b0;
        end
      end
    end
  end

  // Next-state logic for the tally FSM, frame counter, pending and score.
  always_comb begin
    state_next     = state;
    frame_cnt_next = frame_cnt;
    pending_next   = pending;
    score_next     = score;
    pend_sum       = '0;
    if (bus.clearScore) begin
      // Clear wins over everything, including a same-cycle addScore.
      state_next     = S_IDLE;
      frame_cnt_next = '0;
      pending_next   = '0;
      score_next     = '0;
    end else begin
      pend_sum = PSUM_W'(pending);
      if (bus.addScore) begin
        pend_sum = pend_sum + PSUM_W'(bus.addValue);
      end
      case (state)
        S_IDLE: begin
          if (pending != '0) begin
            state_next     = S_WAIT;
            frame_cnt_next = '0;
          end
        end
        S_WAIT: begin
          if (bus.startOfFrame) begin
            if (frame_cnt == CNT_LAST) begin
              state_next = S_STEP;
            end else begin
              frame_cnt_next = frame_cnt + CNT_W'(1);
            end
          end
        end
        S_STEP: begin
          state_next = S_IDLE;
          if (!all_nines) begin
            score_next = score_inc;
            // Pending is at least 1 in STEP, so this never underflows.
            pend_sum   = pend_sum - PSUM_ONE;
          end
        end
        default: begin
          state_next = S_IDLE;
        end
      endcase
      if ((state == S_STEP) && all_nines) begin
        // Score is pinned at the maximum: the remaining points are dropped.
        pending_next = '0;
      end else if (pend_sum > PSUM_MAX) begin
        pending_next = PEND_MAX;
      end else begin
        pending_next = pend_sum[PENDING_WIDTH-1:0];
      end
    end
  end

  // Tally state registers.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state     <= S_IDLE;
      frame_cnt <= '0;
      pending   <= '0;
      score     <= '0;
    end else begin
      state     <= state_next;
      frame_cnt <= frame_cnt_next;
      pending   <= pending_next;
      score     <= score_next;
    end
  end

  // Display snapshot only moves at frame start so a frame never tears; a STEP
  // in the same cycle lands in the following frame.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      displayed <= '0;
    end else if (bus.startOfFrame) begin
      displayed <= score;
    end
  end

  // Leading-zero mask: a digit is blank when it and every more significant
  // digit are zero; the least significant digit always draws.
  always_comb begin
    lead_zero  = 1'b1;
    blank_mask = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      lead_zero     = lead_zero && (displayed[4*i +: 4] == 4'd0);
      blank_mask[i] = lead_zero && (i != 0);
    end
  end

  // Map the scan column to a digit slot; slot 0 is the leftmost (most
  // significant) digit.
  always_comb begin
    slot      = bus.offsetX[10:DIGIT_WIDTH_BITS];
    slot_ext  = 32'(slot);
    slot_ok   = (slot_ext < DIGITS_L);
    pix_digit = '0;
    pix_blank = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (slot_ok && (slot_ext == 32'(NUM_DIGITS - 1 - i))) begin
        pix_digit = displayed[4*i +: 4];
        pix_blank = blank_mask[i];
      end
    end
    pix_inside = bus.InsideRectangle && slot_ok &&
                 (bus.offsetY < HEIGHT_L) && !pix_blank;
  end

  // One register stage on the whole pixel path.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      bus.digitValue   <= '0;
      bus.digitOffsetX <= '0;
      bus.digitOffsetY <= '0;
      bus.digitInside  <= 1'b0;
    end else begin
      bus.digitValue   <= pix_digit;
      bus.digitOffsetX <= {{SLOT_W{1'b0}}, bus.offsetX[DIGIT_WIDTH_BITS-1:0]};
      bus.digitOffsetY <= bus.offsetY;
      bus.digitInside  <= pix_inside;
    end
  end

  assign bus.scoreBCD  = score;
  assign bus.busyTally = (pending != '0) || (state != S_IDLE);
  assign state_dbg     = state;

  // STEP lasts exactly one cycle.
  step_one_cycle: assert property (
    @(posedge clk) disable iff (!resetN) (state == S_STEP) |=> (state == S_IDLE)
  );

endmodule
